gray_updown_counter: RTL

GRAY_UPDOWN_COUNTER -- requirements
Module: gray_updown_counter

---
 rtl/gray_updown_counter.sv | 80 ++++++++
 1 files changed

// File: rtl/gray_updown_counter.sv
// Up/down Gray-code counter with Gray-coded parallel load.
// Keeps a binary shadow so bin_code always matches gray_code.
module gray_updown_counter #(
    parameter int M = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         up_dn,
    input  logic         load,
    input  logic [M-1:0] load_value,
    output logic [M-1:0] gray_code,
    output logic [M-1:0] bin_code,
    output logic         wrap,
    output logic [M-1:0] flip_mask,
    output logic         multi_flip
);

    localparam logic [M-1:0] ONE  = {{(M-1){1'b0}}, 1'b1};
    localparam logic [M-1:0] ZERO = '0;
    localparam logic [M-1:0] ALL1 = '1;

    function automatic logic [M-1:0] g2b(input logic [M-1:0] g);
        logic [M-1:0] b;
        b[M-1] = g[M-1];
        for (int i = M - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [M-1:0] b2g(input logic [M-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [M-1:0] bin_n;
    logic [M-1:0] gray_n;
    logic [M-1:0] flip_n;
    logic         wrap_n;
    logic         multi_n;

    always_comb begin
        bin_n  = bin_code;
        gray_n = gray_code;
        wrap_n = 1'b0;
        if (load) begin
            bin_n  = g2b(load_value);
            gray_n = load_value;
        end else if (enable) begin
            if (up_dn) begin
                bin_n  = bin_code + ONE;
                wrap_n = (bin_code == ALL1);
            end else begin
                bin_n  = bin_code - ONE;
                wrap_n = (bin_code == ZERO);
            end
            gray_n = b2g(bin_n);
        end
        flip_n  = gray_code ^ gray_n;
        // Clearing the lowest set bit leaves nonzero iff two or more were set.
        multi_n = ((flip_n & (flip_n - ONE)) != ZERO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gray_code  <= '0;
            bin_code   <= '0;
            wrap       <= 1'b0;
            flip_mask  <= '0;
            multi_flip <= 1'b0;
        end else begin
            gray_code  <= gray_n;
            bin_code   <= bin_n;
            wrap       <= wrap_n;
            flip_mask  <= flip_n;
            multi_flip <= multi_n;
        end
    end

endmodule
